// File: rtl/anton_neopixel_frame_loader_pkg.sv
// Shared constants for the neopixel frame loader: bus regions, register offsets,
// CTRL bit positions, top FSM state encoding and the CTRL byte builder.
package anton_neopixel_frame_loader_pkg;

    localparam logic [1:0] REGION_VIRTUAL = 2'b00;
    localparam logic [1:0] REGION_DELTA   = 2'b01;
    localparam logic [1:0] REGION_RAW     = 2'b10;
    localparam logic [1:0] REGION_REG     = 2'b11;

    localparam logic [15:0] REG_MAX_LO = 16'd0;
    localparam logic [15:0] REG_MAX_HI = 16'd1;
    localparam logic [15:0] REG_CTRL   = 16'd2;
    localparam logic [15:0] REG_STATE  = 16'd3;

    localparam int CTRL_INIT  = 0;
    localparam int CTRL_LIMIT = 1;
    localparam int CTRL_RUN   = 2;
    localparam int CTRL_LOOP  = 3;
    localparam int CTRL_BIT32 = 4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_POLL,
        S_POLL_STRB,
        S_POLL_GAP,
        S_CTRL0,
        S_MAX_LO,
        S_MAX_HI,
        S_PIX,
        S_CTRL1,
        S_FLUSH,
        S_DONE
    } loaderState_t;

    function automatic logic [7:0] ctrlByte(input logic bit32, input logic loop, input logic run);
        logic [7:0] c;
        c             = '0;
        c[CTRL_LIMIT] = 1'b1;
        c[CTRL_RUN]   = run;
        c[CTRL_LOOP]  = loop;
        c[CTRL_BIT32] = bit32;
        return c;
    endfunction

endpackage

// File: rtl/anton_neopixel_bus_txn.sv
// Single-transaction bus engine: one-cycle strobe, then at least one gap cycle,
// then waits for busReady before accepting the next request.
module anton_neopixel_bus_txn (
    input  logic        busClk,
    input  logic        busRst,
    input  logic        req,
    input  logic        wr,
    input  logic        rd,
    input  logic [17:0] addr,
    input  logic [7:0]  data,
    output logic        ack,
    output logic        free,
    output logic [17:0] busAddr,
    output logic [7:0]  busDataOut,
    output logic        busWrite,
    output logic        busRead,
    input  logic        busReady
);

    // A strobe cycle is never free, which guarantees the gap cycle after it.
    assign free = !(busWrite || busRead) && busReady;
    assign ack  = req && free;

    always_ff @(posedge busClk or posedge busRst) begin
        if (busRst) begin
            busAddr    <= '0;
            busDataOut <= '0;
            busWrite   <= 1'b0;
            busRead    <= 1'b0;
        end else begin
            busWrite <= ack && wr;
            busRead  <= ack && rd;
            if (ack) begin
                busAddr    <= addr;
                busDataOut <= data;
            end
        end
    end

endmodule

// File: rtl/anton_neopixel_frame_loader.sv
// Host-side bus initiator: programs CTRL/MAX, streams pixel bytes, then sets RUN.
// Optional status polling before CTRL0 is built when ANTON_NEOPIXEL_LOADER_POLL_EN is defined.
module anton_neopixel_frame_loader
    import anton_neopixel_frame_loader_pkg::*;
#(
    parameter int LEN_BITS = 13,
    parameter int IDX_BITS = 16
) (
    input  logic                busClk,
    input  logic                busRst,
    input  logic                cmdStart,
    input  logic [LEN_BITS-1:0] cmdLen,
    input  logic                cmdVirtual,
    input  logic                cmdLoop,
    input  logic                cmd32bit,
    output logic                cmdBusy,
    output logic                cmdDone,
    input  logic [7:0]          inData,
    input  logic                inValid,
    output logic                inReady,
    output logic [17:0]         busAddr,
    output logic [7:0]          busDataOut,
    output logic                busWrite,
    output logic                busRead,
    input  logic [7:0]          busDataIn,
    input  logic                busReady
);

    loaderState_t        state, stateNext;
    logic [LEN_BITS-1:0] lenQ;
    logic                virtQ, loopQ, b32Q;
    logic [IDX_BITS-1:0] idx;

    logic        txnReq, txnWr, txnRd, txnAck, txnFree;
    logic [17:0] txnAddr;
    logic [7:0]  txnData;
    logic        lastPix;

    assign lastPix = (idx == IDX_BITS'(lenQ));
    assign cmdBusy = (state != S_IDLE) && (state != S_DONE);

`ifndef ANTON_NEOPIXEL_LOADER_POLL_EN
    logic unusedBusData;
    assign unusedBusData = ^busDataIn;
`endif

    always_comb begin
        stateNext = state;
        txnReq    = 1'b0;
        txnWr     = 1'b1;
        txnRd     = 1'b0;
        txnAddr   = {REGION_REG, REG_CTRL};
        txnData   = ctrlByte(b32Q, loopQ, 1'b0);
        inReady   = 1'b0;
        cmdDone   = 1'b0;
        case (state)
            S_IDLE: begin
`ifdef ANTON_NEOPIXEL_LOADER_POLL_EN
                if (cmdStart) stateNext = S_POLL;
`else
                if (cmdStart) stateNext = S_CTRL0;
`endif
            end
`ifdef ANTON_NEOPIXEL_LOADER_POLL_EN
            S_POLL: begin
                txnReq  = 1'b1;
                txnWr   = 1'b0;
                txnRd   = 1'b1;
                txnAddr = {REGION_REG, REG_STATE};
                if (txnAck) stateNext = S_POLL_STRB;
            end
            S_POLL_STRB: stateNext = S_POLL_GAP;
            // Read data is valid in the gap cycle; a busy responder costs one idle cycle.
            S_POLL_GAP: stateNext = busDataIn[0] ? S_POLL : S_CTRL0;
`endif
            S_CTRL0: begin
                txnReq = 1'b1;
                if (txnAck) stateNext = S_MAX_LO;
            end
            S_MAX_LO: begin
                txnReq  = 1'b1;
                txnAddr = {REGION_REG, REG_MAX_LO};
                txnData = lenQ[7:0];
                if (txnAck) stateNext = S_MAX_HI;
            end
            S_MAX_HI: begin
                txnReq  = 1'b1;
                txnAddr = {REGION_REG, REG_MAX_HI};
                txnData = 8'(lenQ >> 8);
                if (txnAck) stateNext = S_PIX;
            end
            S_PIX: begin
                txnReq  = inValid;
                txnAddr = {virtQ ? REGION_VIRTUAL : REGION_RAW, idx};
                txnData = inData;
                inReady = txnAck;
                if (txnAck && lastPix) stateNext = S_CTRL1;
            end
            S_CTRL1: begin
                txnReq  = 1'b1;
                txnData = ctrlByte(b32Q, loopQ, 1'b1);
                if (txnAck) stateNext = S_FLUSH;
            end
            // Done is only reported once the RUN write has fully retired on the bus.
            S_FLUSH: if (txnFree) stateNext = S_DONE;
            S_DONE: begin
                cmdDone   = 1'b1;
                stateNext = S_IDLE;
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge busClk or posedge busRst) begin
        if (busRst) begin
            state <= S_IDLE;
            lenQ  <= '0;
            virtQ <= 1'b0;
            loopQ <= 1'b0;
            b32Q  <= 1'b0;
            idx   <= '0;
        end else begin
            state <= stateNext;
            if (state == S_IDLE && cmdStart) begin
                lenQ  <= cmdLen;
                virtQ <= cmdVirtual;
                loopQ <= cmdLoop;
                b32Q  <= cmd32bit;
                idx   <= '0;
            end else if (state == S_PIX && txnAck) begin
                idx <= idx + 1'b1;
            end
        end
    end

    anton_neopixel_bus_txn uTxn (
        .busClk     (busClk),
        .busRst     (busRst),
        .req        (txnReq),
        .wr         (txnWr),
        .rd         (txnRd),
        .addr       (txnAddr),
        .data       (txnData),
        .ack        (txnAck),
        .free       (txnFree),
        .busAddr    (busAddr),
        .busDataOut (busDataOut),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busReady   (busReady)
    );

endmodule

// File: tb/tb_anton_neopixel_frame_loader.sv
// Directed self-checking bench for anton_neopixel_frame_loader with a small bus responder model.
module tb_anton_neopixel_frame_loader;

    logic        busClk = 1'b0;
    logic        busRst;
    logic        cmdStart;
    logic [12:0] cmdLen;
    logic        cmdVirtual, cmdLoop, cmd32bit;
    logic        cmdBusy, cmdDone;
    logic [7:0]  inData;
    logic        inValid, inReady;
    logic [17:0] busAddr;
    logic [7:0]  busDataOut;
    logic        busWrite, busRead;
    logic [7:0]  busDataIn = 8'h00;
    logic        busReady;

    int checks = 0;
    int errors = 0;

    always #5 busClk = ~busClk;

    anton_neopixel_frame_loader dut (
        .busClk     (busClk),
        .busRst     (busRst),
        .cmdStart   (cmdStart),
        .cmdLen     (cmdLen),
        .cmdVirtual (cmdVirtual),
        .cmdLoop    (cmdLoop),
        .cmd32bit   (cmd32bit),
        .cmdBusy    (cmdBusy),
        .cmdDone    (cmdDone),
        .inData     (inData),
        .inValid    (inValid),
        .inReady    (inReady),
        .busAddr    (busAddr),
        .busDataOut (busDataOut),
        .busWrite   (busWrite),
        .busRead    (busRead),
        .busDataIn  (busDataIn),
        .busReady   (busReady)
    );

    // Responder: virtual writes hold busReady low for 6 cycles after the strobe.
    int   cyc = 0;
    int   holdCnt = 0;
    int   rdTotal = 0;
    int   pollMark = 0;
    int   pollBusyReads = 0;
    logic readyForce = 1'b1;

    assign busReady = readyForce && (holdCnt == 0);

    always @(posedge busClk) begin
        cyc <= cyc + 1;
        if (busWrite && busAddr[17:16] == 2'b00) holdCnt <= 6;
        else if (holdCnt > 0) holdCnt <= holdCnt - 1;
        if (busRead) begin
            busDataIn <= ((rdTotal - pollMark) < pollBusyReads) ? 8'h01 : 8'h00;
            rdTotal   <= rdTotal + 1;
        end
    end

    logic [17:0] wAddr[$];
    logic [7:0]  wData[$];
    int          wCyc[$];
    logic [17:0] rAddr[$];
    int          rCyc[$];
    logic [7:0]  cData[$];
    int          cCyc[$];
    int          doneCnt = 0;
    int          doneCyc = 0;

    always @(negedge busClk) begin
        if (busWrite) begin
            wAddr.push_back(busAddr);
            wData.push_back(busDataOut);
            wCyc.push_back(cyc);
        end
        if (busRead) begin
            rAddr.push_back(busAddr);
            rCyc.push_back(cyc);
        end
        if (inValid && inReady) begin
            cData.push_back(inData);
            cCyc.push_back(cyc);
        end
        if (cmdDone) begin
            doneCnt = doneCnt + 1;
            doneCyc = cyc;
        end
    end

    logic [7:0] frame [0:8191];
    int         relCyc = 0;

    task automatic runFrame(input int len, input bit virt, input bit loop, input bit b32,
                            input int period, input int holdReady, input int midStartAt);
        int pos;
        int t;
        int doneMark;
        doneMark = doneCnt;
        pos = 0;
        t = 0;
        @(posedge busClk); #1;
        cmdLen     = 13'(len);
        cmdVirtual = virt;
        cmdLoop    = loop;
        cmd32bit   = b32;
        cmdStart   = 1'b1;
        readyForce = (holdReady == 0);
        @(posedge busClk); #1;
        cmdStart = 1'b0;
        while (doneCnt == doneMark && t < 40000) begin
            if (t == holdReady) begin
                readyForce = 1'b1;
                relCyc = cyc;
            end
            if (t == midStartAt) begin
                cmdStart   = 1'b1;
                cmdLen     = 13'd7;
                cmdVirtual = ~virt;
                cmd32bit   = ~b32;
            end else begin
                cmdStart = 1'b0;
            end
            inValid = (pos <= len) && (period <= 1 || (t % period) == 0);
            inData  = (pos <= len) ? frame[pos] : 8'h00;
            @(negedge busClk);
            if (inValid && inReady) pos++;
            @(posedge busClk); #1;
            t++;
        end
        inValid  = 1'b0;
        cmdStart = 1'b0;
        checks++;
        if (doneCnt == doneMark) begin
            errors++;
            $display("FAIL frame_timeout len=%0d got no cmdDone want cmdDone within 40000 cycles", len);
        end
        repeat (2) @(posedge busClk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge busClk);
        checks++;
        if ({cmdBusy, cmdDone, inReady, busWrite, busRead, busAddr, busDataOut} !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {cmdBusy, cmdDone, inReady, busWrite, busRead, busAddr, busDataOut});
        end
        @(posedge busClk); #1;
        busRst = 1'b0;
        @(negedge busClk);
        checks++;
        if ({cmdBusy, cmdDone, busWrite, busRead} !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 0000", {cmdBusy, cmdDone, busWrite, busRead});
        end
    endtask

    task automatic test_raw_frame();
        logic [17:0] expA [8] = '{18'h30002, 18'h30000, 18'h30001, 18'h20000,
                                  18'h20001, 18'h20002, 18'h20003, 18'h30002};
        logic [7:0]  expD [8] = '{8'h02, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h06};
        int wBase, cBase, dMark, n;
        wBase = wAddr.size();
        cBase = cData.size();
        dMark = doneCnt;
        frame[0] = 8'h11; frame[1] = 8'h22; frame[2] = 8'h33; frame[3] = 8'h44;
        runFrame(3, 1'b0, 1'b0, 1'b0, 1, 0, -1);
        n = wAddr.size() - wBase;
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL t1_write_count got %0d want 8", n);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wAddr[wBase+i] !== expA[i] || wData[wBase+i] !== expD[i]) begin
                    errors++;
                    $display("FAIL t1_write[%0d] got %h/%h want %h/%h", i,
                             wAddr[wBase+i], wData[wBase+i], expA[i], expD[i]);
                end
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (wCyc[wBase+i] - wCyc[wBase+i-1] != 2) begin
                    errors++;
                    $display("FAIL t1_spacing[%0d] got %0d want 2", i, wCyc[wBase+i] - wCyc[wBase+i-1]);
                end
            end
            checks++;
            if (doneCyc - wCyc[wBase+7] != 2) begin
                errors++;
                $display("FAIL t1_done_latency got %0d want 2", doneCyc - wCyc[wBase+7]);
            end
        end
        checks++;
        if (doneCnt - dMark != 1) begin
            errors++;
            $display("FAIL t1_done_count got %0d want 1", doneCnt - dMark);
        end
        checks++;
        if (cData.size() - cBase != 4) begin
            errors++;
            $display("FAIL t1_consumed got %0d want 4", cData.size() - cBase);
        end
    endtask

    task automatic test_virtual_frame();
        int wBase, n;
        wBase = wAddr.size();
        frame[0] = 8'hAA; frame[1] = 8'h55;
        runFrame(1, 1'b1, 1'b1, 1'b1, 1, 0, -1);
        n = wAddr.size() - wBase;
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL t2_write_count got %0d want 6", n);
        end else begin
            checks++;
            if (wData[wBase] !== 8'h1A) begin
                errors++;
                $display("FAIL t2_ctrl0 got %h want 1a", wData[wBase]);
            end
            checks++;
            if (wAddr[wBase+3] !== 18'h00000 || wData[wBase+3] !== 8'hAA) begin
                errors++;
                $display("FAIL t2_pix0 got %h/%h want 00000/aa", wAddr[wBase+3], wData[wBase+3]);
            end
            checks++;
            if (wAddr[wBase+4] !== 18'h00001 || wData[wBase+4] !== 8'h55) begin
                errors++;
                $display("FAIL t2_pix1 got %h/%h want 00001/55", wAddr[wBase+4], wData[wBase+4]);
            end
            checks++;
            if (wCyc[wBase+4] - wCyc[wBase+3] != 8) begin
                errors++;
                $display("FAIL t2_pix_spacing got %0d want 8", wCyc[wBase+4] - wCyc[wBase+3]);
            end
            checks++;
            if (wCyc[wBase+5] - wCyc[wBase+4] != 8) begin
                errors++;
                $display("FAIL t2_ctrl1_spacing got %0d want 8", wCyc[wBase+5] - wCyc[wBase+4]);
            end
            checks++;
            if (wAddr[wBase+5] !== 18'h30002 || wData[wBase+5] !== 8'h1E) begin
                errors++;
                $display("FAIL t2_ctrl1 got %h/%h want 30002/1e", wAddr[wBase+5], wData[wBase+5]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] expB [6] = '{8'h01, 8'h12, 8'h23, 8'h34, 8'h45, 8'h56};
        int wBase, cBase, nc;
        wBase = wAddr.size();
        cBase = cData.size();
        for (int i = 0; i < 6; i++) frame[i] = expB[i];
        runFrame(5, 1'b0, 1'b0, 1'b0, 3, 0, -1);
        nc = cData.size() - cBase;
        checks++;
        if (nc != 6 || (wAddr.size() - wBase) != 10) begin
            errors++;
            $display("FAIL t3_counts got %0d bytes/%0d writes want 6/10", nc, wAddr.size() - wBase);
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (cData[cBase+i] !== expB[i] || wData[wBase+3+i] !== expB[i]
                    || wAddr[wBase+3+i] !== 18'(18'h20000 + i)) begin
                    errors++;
                    $display("FAIL t3_byte[%0d] got in %h bus %h@%h want %h", i,
                             cData[cBase+i], wData[wBase+3+i], wAddr[wBase+3+i], expB[i]);
                end
                checks++;
                if (wCyc[wBase+3+i] != cCyc[cBase+i] + 1) begin
                    errors++;
                    $display("FAIL t3_strobe_timing[%0d] got cycle %0d want %0d", i,
                             wCyc[wBase+3+i], cCyc[cBase+i] + 1);
                end
            end
        end
    endtask

    task automatic test_ignore_start();
        int wBase, dMark, n;
        wBase = wAddr.size();
        dMark = doneCnt;
        for (int i = 0; i < 8; i++) frame[i] = 8'(8'hC0 + i);
        runFrame(3, 1'b0, 1'b0, 1'b0, 1, 0, 6);
        n = wAddr.size() - wBase;
        checks++;
        if (n != 8 || doneCnt - dMark != 1) begin
            errors++;
            $display("FAIL t4_ignore_counts got %0d writes/%0d done want 8/1", n, doneCnt - dMark);
        end else begin
            checks++;
            if (wData[wBase+1] !== 8'h03 || wAddr[wBase+6] !== 18'h20003 || wData[wBase+7] !== 8'h06) begin
                errors++;
                $display("FAIL t4_latched got max %h last %h ctrl %h want 03 20003 06",
                         wData[wBase+1], wAddr[wBase+6], wData[wBase+7]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int wBase, dMark, w, n;
        wBase = wAddr.size();
        dMark = doneCnt;
        @(posedge busClk); #1;
        cmdLen = 13'd20; cmdVirtual = 1'b0; cmdLoop = 1'b0; cmd32bit = 1'b0;
        cmdStart = 1'b1; inValid = 1'b1; inData = 8'h5A;
        @(posedge busClk); #1;
        cmdStart = 1'b0;
        w = 0;
        while ((wAddr.size() - wBase) < 5 && w < 200) begin
            @(negedge busClk);
            w++;
        end
        checks++;
        if ((wAddr.size() - wBase) < 5) begin
            errors++;
            $display("FAIL t4_reach_pix got %0d writes want 5", wAddr.size() - wBase);
        end
        @(posedge busClk); #1;
        busRst = 1'b1;
        #1;
        checks++;
        if ({cmdBusy, cmdDone, inReady, busWrite, busRead, busAddr, busDataOut} !== 31'd0) begin
            errors++;
            $display("FAIL t4_reset_outputs got %h want 0",
                     {cmdBusy, cmdDone, inReady, busWrite, busRead, busAddr, busDataOut});
        end
        inValid = 1'b0;
        repeat (2) @(posedge busClk);
        #1;
        busRst = 1'b0;
        @(negedge busClk);
        checks++;
        if (doneCnt != dMark || cmdBusy !== 1'b0) begin
            errors++;
            $display("FAIL t4_no_done got done %0d busy %b want 0 0", doneCnt - dMark, cmdBusy);
        end
        wBase = wAddr.size();
        frame[0] = 8'h77;
        runFrame(0, 1'b0, 1'b0, 1'b0, 1, 0, -1);
        n = wAddr.size() - wBase;
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL t4_restart_count got %0d want 5", n);
        end else begin
            checks++;
            if (wAddr[wBase] !== 18'h30002 || wData[wBase] !== 8'h02
                || wAddr[wBase+3] !== 18'h20000 || wData[wBase+3] !== 8'h77) begin
                errors++;
                $display("FAIL t4_restart got %h/%h pix %h/%h want 30002/02 pix 20000/77",
                         wAddr[wBase], wData[wBase], wAddr[wBase+3], wData[wBase+3]);
            end
        end
    endtask

    task automatic test_ready_low_idle();
        int wBase, rBase, first;
        wBase = wAddr.size();
        rBase = rAddr.size();
        frame[0] = 8'h99;
        runFrame(0, 1'b0, 1'b0, 1'b0, 1, 5, -1);
        checks++;
`ifdef ANTON_NEOPIXEL_LOADER_POLL_EN
        first = (rAddr.size() > rBase) ? rCyc[rBase] : -1;
`else
        first = (wAddr.size() > wBase) ? wCyc[wBase] : -1;
`endif
        if (first != relCyc + 1) begin
            errors++;
            $display("FAIL ready_low_first_strobe got cycle %0d want %0d", first, relCyc + 1);
        end
    endtask

    task automatic test_max_len();
        int wBase, cBase, n;
        wBase = wAddr.size();
        cBase = cData.size();
        for (int i = 0; i < 8192; i++) frame[i] = 8'(i) ^ 8'h3C;
        runFrame(8191, 1'b0, 1'b0, 1'b0, 1, 0, -1);
        n = wAddr.size() - wBase;
        checks++;
        if (n != 8196 || (cData.size() - cBase) != 8192) begin
            errors++;
            $display("FAIL t5_counts got %0d writes/%0d bytes want 8196/8192", n, cData.size() - cBase);
        end else begin
            checks++;
            if (wData[wBase+1] !== 8'hFF || wData[wBase+2] !== 8'h1F) begin
                errors++;
                $display("FAIL t5_max got lo %h hi %h want ff 1f", wData[wBase+1], wData[wBase+2]);
            end
            checks++;
            if (wAddr[wBase+8194] !== 18'h21FFF || wData[wBase+8194] !== 8'hC3) begin
                errors++;
                $display("FAIL t5_last_pix got %h/%h want 21fff/c3", wAddr[wBase+8194], wData[wBase+8194]);
            end
        end
    endtask

    task automatic test_poll();
`ifdef ANTON_NEOPIXEL_LOADER_POLL_EN
        int wBase, rBase, n;
        wBase = wAddr.size();
        rBase = rAddr.size();
        pollMark = rdTotal;
        pollBusyReads = 2;
        frame[0] = 8'h42;
        runFrame(0, 1'b0, 1'b0, 1'b0, 1, 0, -1);
        n = rAddr.size() - rBase;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL t6_read_count got %0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rAddr[rBase+i] !== 18'h30003) begin
                    errors++;
                    $display("FAIL t6_read_addr[%0d] got %h want 30003", i, rAddr[rBase+i]);
                end
            end
            checks++;
            if (rCyc[rBase+1] - rCyc[rBase] != 3 || rCyc[rBase+2] - rCyc[rBase+1] != 3) begin
                errors++;
                $display("FAIL t6_read_spacing got %0d,%0d want 3,3",
                         rCyc[rBase+1] - rCyc[rBase], rCyc[rBase+2] - rCyc[rBase+1]);
            end
            checks++;
            if (wAddr[wBase] !== 18'h30002 || wCyc[wBase] - rCyc[rBase+2] != 3) begin
                errors++;
                $display("FAIL t6_ctrl0_after_poll got %h after %0d want 30002 after 3",
                         wAddr[wBase], wCyc[wBase] - rCyc[rBase+2]);
            end
        end
        pollBusyReads = 0;
`else
        checks++;
        if (rAddr.size() != 0) begin
            errors++;
            $display("FAIL t6_no_reads got %0d reads want 0", rAddr.size());
        end
`endif
    endtask

    initial begin
        busRst = 1'b1;
        cmdStart = 1'b0;
        cmdLen = 13'd0;
        cmdVirtual = 1'b0;
        cmdLoop = 1'b0;
        cmd32bit = 1'b0;
        inData = 8'h00;
        inValid = 1'b0;
        test_reset();
        test_raw_frame();
        test_virtual_frame();
        test_stall();
        test_ignore_start();
        test_reset_midframe();
        test_ready_low_idle();
        test_max_len();
        test_poll();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
